// File: rtl/mat_stream_ctrl.sv
// mat_stream_ctrl: front-end sequencer for the matrix datapath.
//
// Takes one command over a byte stream (opcode, 1024 bytes of A, 1024 bytes of B), writes A
// and B into their BRAM write ports, launches the calc engine, waits for it to finish, then
// streams back either all 1024 bytes of C (read from BRAM C) or a single trace byte.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   s_data/s_valid/s_ready    command/data byte input stream
//   m_data/m_valid/m_ready    result byte output stream
//   addra_w/dina/wea          BRAM A write port (one-cycle registered pulses)
//   addrb_w/dinb/web          BRAM B write port (one-cycle registered pulses)
//   op/op_start/finish        calc engine control; op held from launch until done
//   dout_C                    calc result bus, carries the trace value for ops 110/111
//   addrc_r/doutc             BRAM C read port, data valid one cycle after address
//   busy                      high whenever the sequencer is not idle
module mat_stream_ctrl #(
    parameter int unsigned N_ELEM   = 1024,
    parameter int unsigned C_RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [9:0] addra_w,
    output logic [7:0] dina,
    output logic       wea,
    output logic [9:0] addrb_w,
    output logic [7:0] dinb,
    output logic       web,
    output logic [2:0] op,
    output logic       op_start,
    input  logic       finish,
    input  logic [7:0] dout_C,
    output logic [9:0] addrc_r,
    input  logic [7:0] doutc,
    output logic       busy
);

    // Address width and the read pipeline are hard-wired to these values.
    if (N_ELEM != 1024 || C_RD_LAT != 1) begin : g_param_check
        $error("mat_stream_ctrl supports only N_ELEM=1024 and C_RD_LAT=1");
    end

    localparam logic [10:0] LastIdx = 11'(N_ELEM - 1);

    typedef enum logic [3:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StStart,
        StWait,
        StRdAddr,
        StRdData,
        StOut,
        StTraceOut
    } state_t;

    state_t      r_state;
    logic [10:0] r_cnt;
    logic        r_seen_low;
    logic        r_s_ready;
    logic [7:0]  r_m_data;
    logic        r_m_valid;
    logic [9:0]  r_addra;
    logic [7:0]  r_dina;
    logic        r_wea;
    logic [9:0]  r_addrb;
    logic [7:0]  r_dinb;
    logic        r_web;
    logic [2:0]  r_op;
    logic        r_op_start;
    logic [9:0]  r_addrc;

    logic w_s_hs;
    logic w_m_hs;
    logic w_last;
    logic w_trace_op;

    assign w_s_hs     = s_valid & r_s_ready;
    assign w_m_hs     = r_m_valid & m_ready;
    assign w_last     = (r_cnt == LastIdx);
    assign w_trace_op = (r_op[2:1] == 2'b11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_seen_low <= 1'b0;
            r_s_ready  <= 1'b0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_addra    <= '0;
            r_dina     <= '0;
            r_wea      <= 1'b0;
            r_addrb    <= '0;
            r_dinb     <= '0;
            r_web      <= 1'b0;
            r_op       <= '0;
            r_op_start <= 1'b0;
            r_addrc    <= '0;
        end else begin
            // Write strobes and the launch pulse last a single cycle unless re-asserted.
            r_wea      <= 1'b0;
            r_web      <= 1'b0;
            r_op_start <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    r_s_ready <= 1'b1;
                    if (w_s_hs) begin
                        r_op    <= s_data[2:0];
                        r_cnt   <= '0;
                        r_state <= StLoadA;
                    end
                end

                StLoadA: begin
                    if (w_s_hs) begin
                        r_wea   <= 1'b1;
                        r_addra <= r_cnt[9:0];
                        r_dina  <= s_data;
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= StLoadB;
                        end else begin
                            r_cnt <= r_cnt + 11'd1;
                        end
                    end
                end

                StLoadB: begin
                    if (w_s_hs) begin
                        r_web   <= 1'b1;
                        r_addrb <= r_cnt[9:0];
                        r_dinb  <= s_data;
                        if (w_last) begin
                            r_cnt      <= '0;
                            r_s_ready  <= 1'b0;
                            // Raised on entry so the pulse coincides with the START cycle.
                            r_op_start <= 1'b1;
                            r_state    <= StStart;
                        end else begin
                            r_cnt <= r_cnt + 11'd1;
                        end
                    end
                end

                StStart: begin
                    r_seen_low <= 1'b0;
                    r_state    <= StWait;
                end

                // finish is sticky from the previous run; only a high that follows an
                // observed low belongs to this launch.
                StWait: begin
                    if (!finish) begin
                        r_seen_low <= 1'b1;
                    end else if (r_seen_low) begin
                        if (w_trace_op) begin
                            r_m_data  <= dout_C;
                            r_m_valid <= 1'b1;
                            r_state   <= StTraceOut;
                        end else begin
                            r_cnt   <= '0;
                            r_addrc <= '0;
                            r_state <= StRdAddr;
                        end
                    end
                end

                // addrc_r was loaded on entry, so the BRAM samples it at the end of this
                // cycle and doutc is valid throughout RD_DATA.
                StRdAddr: begin
                    r_state <= StRdData;
                end

                StRdData: begin
                    r_m_data  <= doutc;
                    r_m_valid <= 1'b1;
                    r_state   <= StOut;
                end

                StOut: begin
                    if (w_m_hs) begin
                        r_m_valid <= 1'b0;
                        if (w_last) begin
                            r_s_ready <= 1'b1;
                            r_state   <= StIdle;
                        end else begin
                            r_cnt   <= r_cnt + 11'd1;
                            r_addrc <= r_cnt[9:0] + 10'd1;
                            r_state <= StRdAddr;
                        end
                    end
                end

                StTraceOut: begin
                    if (w_m_hs) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= StIdle;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign s_ready  = r_s_ready;
    assign m_data   = r_m_data;
    assign m_valid  = r_m_valid;
    assign addra_w  = r_addra;
    assign dina     = r_dina;
    assign wea      = r_wea;
    assign addrb_w  = r_addrb;
    assign dinb     = r_dinb;
    assign web      = r_web;
    assign op       = r_op;
    assign op_start = r_op_start;
    assign addrc_r  = r_addrc;
    assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_mat_stream_ctrl.sv
// Testbench for mat_stream_ctrl: BRAM and calc-engine models around the DUT, a reference
// model computing result bytes from the transmitted matrices, directed command sequence.
module tb_mat_stream_ctrl;

    localparam int N = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [9:0] addra_w;
    logic [7:0] dina;
    logic       wea;
    logic [9:0] addrb_w;
    logic [7:0] dinb;
    logic       web;
    logic [2:0] op;
    logic       op_start;
    logic       finish;
    logic [7:0] dout_c;
    logic [9:0] addrc_r;
    logic [7:0] doutc;
    logic       busy;

    always #5 clk = ~clk;

    mat_stream_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .addra_w  (addra_w),
        .dina     (dina),
        .wea      (wea),
        .addrb_w  (addrb_w),
        .dinb     (dinb),
        .web      (web),
        .op       (op),
        .op_start (op_start),
        .finish   (finish),
        .dout_C   (dout_c),
        .addrc_r  (addrc_r),
        .doutc    (doutc),
        .busy     (busy)
    );

    // Stimulus matrices (what the bench sends) and BRAM contents (what the DUT wrote).
    logic [7:0] src_a [N];
    logic [7:0] src_b [N];
    logic [7:0] mem_a [N];
    logic [7:0] mem_b [N];
    logic [7:0] mem_c [N];

    int n_checks = 0;
    int n_pass   = 0;
    int n_wea    = 0;
    int n_web    = 0;
    int n_start  = 0;
    int n_early  = 0;
    bit stale_mode = 1'b0;
    int calc_lat   = 5;
    bit finish_rose;

    always @(posedge clk) begin
        if (wea) mem_a[addra_w] <= dina;
        if (web) mem_b[addrb_w] <= dinb;
        doutc <= mem_c[addrc_r];
    end

    always @(negedge clk) begin
        if (wea) n_wea++;
        if (web) n_web++;
        // A result must never appear before the calc of this run has raised finish.
        if (busy && m_valid && !finish_rose) n_early++;
    end

    // Calc engine: clears finish on op_start (or 2 cycles later in stale mode), computes C
    // from the BRAMs after a latency, then raises finish.
    initial begin : calc_model
        logic [2:0] cop;
        int         tr;
        finish      = 1'b0;
        dout_c      = 8'h00;
        finish_rose = 1'b1;
        forever begin
            @(negedge clk);
            if (op_start === 1'b1) begin
                n_start++;
                cop = op;
                finish_rose = 1'b0;
                if (stale_mode) repeat (2) @(negedge clk);
                finish = 1'b0;
                repeat (calc_lat) @(negedge clk);
                tr = 0;
                for (int i = 0; i < 32; i++) tr += int'(mem_a[33 * i]);
                for (int i = 0; i < 32; i++) begin
                    for (int j = 0; j < 32; j++) begin
                        if (cop == 3'b000) mem_c[32 * i + j] = mem_a[32 * i + j] + mem_b[32 * i + j];
                        else if (cop == 3'b100) mem_c[32 * i + j] = mem_a[32 * j + i];
                        else mem_c[32 * i + j] = mem_a[32 * i + j];
                    end
                end
                dout_c      = (cop[2:1] == 2'b11) ? 8'(tr) : 8'(~tr);
                finish      = 1'b1;
                finish_rose = 1'b1;
            end
        end
    end

    // Reference: byte k of the result stream for opcode o, from the transmitted matrices.
    function automatic logic [7:0] exp_byte(input logic [2:0] o, input int k);
        int i;
        int j;
        int sum;
        i = k / 32;
        j = k % 32;
        if (o[2:1] == 2'b11) begin
            sum = 0;
            for (int d = 0; d < 32; d++) sum += int'(src_a[33 * d]);
            return 8'(sum);
        end
        if (o == 3'b100) return src_a[32 * j + i];
        return 8'(int'(src_a[k]) + int'(src_b[k]));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the handshake.
    task automatic send_byte(input logic [7:0] b, input int vpct);
        int guard;
        guard = 0;
        while (int'($urandom_range(99, 0)) >= vpct) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("s_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic recv(input logic [2:0] eop, input int n, input bit bp,
                        output int got_n, output int bad, output int unstable);
        int         cyc;
        bit         hold;
        logic [7:0] held;
        cyc = 0; hold = 1'b0; held = 8'h00;
        got_n = 0; bad = 0; unstable = 0;
        while (got_n < n && cyc < 20000) begin
            m_ready = bp ? ((cyc % 3) == 0) : 1'b1;
            if (hold && !(m_valid === 1'b1 && m_data === held)) unstable++;
            if (m_valid && m_ready) begin
                if (m_data !== exp_byte(eop, got_n)) bad++;
                got_n++;
                hold = 1'b0;
            end else begin
                hold = m_valid;
                held = m_data;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ":s_ready"},  32'(s_ready),  32'd0);
        chk({tag, ":m_valid"},  32'(m_valid),  32'd0);
        chk({tag, ":m_data"},   32'(m_data),   32'd0);
        chk({tag, ":wea_web"},  32'({wea, web}), 32'd0);
        chk({tag, ":addrs"},    32'({addra_w, addrb_w, addrc_r}), 32'd0);
        chk({tag, ":din"},      32'({dina, dinb}), 32'd0);
        chk({tag, ":op"},       32'({op, op_start}), 32'd0);
        chk({tag, ":busy"},     32'(busy),     32'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] opc, input int vpct,
                           input bit bp, input bit stale);
        int         wa0, wb0, st0, er0;
        logic [2:0] eop;
        int         nout, got_n, bad, unstable, extra, amis, bmis;
        wa0 = n_wea; wb0 = n_web; st0 = n_start; er0 = n_early;
        eop = opc[2:0];
        nout = (eop[2:1] == 2'b11) ? 1 : N;
        stale_mode = stale;
        calc_lat = int'($urandom_range(20, 3));
        send_byte(opc, vpct);
        chk({tag, ":op_latch"}, 32'(op), 32'(eop));
        chk({tag, ":busy_load"}, 32'(busy), 32'd1);
        for (int k = 0; k < N; k++) send_byte(src_a[k], vpct);
        for (int k = 0; k < N; k++) send_byte(src_b[k], vpct);
        s_valid = 1'b0;
        chk({tag, ":s_ready_post_load"}, 32'(s_ready), 32'd0);
        recv(eop, nout, bp, got_n, bad, unstable);
        chk({tag, ":busy_done"}, 32'(busy), 32'd0);
        chk({tag, ":s_ready_done"}, 32'(s_ready), 32'd1);
        extra = 0;
        m_ready = 1'b1;
        repeat (8) begin
            if (m_valid) extra++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        amis = 0; bmis = 0;
        for (int k = 0; k < N; k++) begin
            if (mem_a[k] !== src_a[k]) amis++;
            if (mem_b[k] !== src_b[k]) bmis++;
        end
        chk({tag, ":wea_pulses"}, 32'(n_wea - wa0), 32'(N));
        chk({tag, ":web_pulses"}, 32'(n_web - wb0), 32'(N));
        chk({tag, ":bram_a_mismatches"}, 32'(amis), 32'd0);
        chk({tag, ":bram_b_mismatches"}, 32'(bmis), 32'd0);
        chk({tag, ":op_start_count"}, 32'(n_start - st0), 32'd1);
        chk({tag, ":op_hold"}, 32'(op), 32'(eop));
        chk({tag, ":early_output"}, 32'(n_early - er0), 32'd0);
        chk({tag, ":bytes_out"}, 32'(got_n), 32'(nout));
        chk({tag, ":bad_bytes"}, 32'(bad), 32'd0);
        chk({tag, ":unstable_hold"}, 32'(unstable), 32'd0);
        chk({tag, ":extra_bytes"}, 32'(extra), 32'd0);
    endtask

    initial begin : stimulus
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Add, A[k]=k, B[k]=1.
        for (int k = 0; k < N; k++) begin
            src_a[k] = 8'(k);
            src_b[k] = 8'h01;
        end
        run_cmd("add_directed", 8'h00, 100, 1'b0, 1'b0);

        // Transpose; upper opcode bits must be ignored.
        for (int k = 0; k < N; k++) src_b[k] = 8'($urandom);
        run_cmd("transpose", 8'hFC, 100, 1'b0, 1'b0);

        // Trace: a single byte.
        for (int k = 0; k < N; k++) src_a[k] = 8'($urandom);
        run_cmd("trace", 8'h06, 100, 1'b0, 1'b0);

        // Stale finish from the previous run, dropped two cycles after the launch.
        for (int k = 0; k < N; k++) begin
            src_a[k] = 8'($urandom);
            src_b[k] = 8'($urandom);
        end
        run_cmd("stale_finish", 8'h00, 100, 1'b0, 1'b1);

        // Backpressure and input gaps.
        for (int k = 0; k < N; k++) begin
            src_a[k] = 8'(k);
            src_b[k] = 8'h01;
        end
        run_cmd("backpressure", 8'h00, 50, 1'b1, 1'b0);

        // Reset in LOAD_B after 500 bytes of B.
        begin
            int st0;
            st0 = n_start;
            send_byte(8'h00, 100);
            for (int k = 0; k < N; k++) send_byte(8'($urandom), 100);
            for (int k = 0; k < 500; k++) send_byte(8'($urandom), 100);
            s_valid = 1'b0;
            #2;
            rst = 1'b1;
            #1;
            check_reset_vals("mid_reset");
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            chk("mid_reset:no_launch", 32'(n_start - st0), 32'd0);
            chk("mid_reset:idle_ready", 32'({busy, s_ready, m_valid}), 32'b010);
        end

        // Next command after the reset is accepted normally.
        for (int k = 0; k < N; k++) begin
            src_a[k] = 8'($urandom);
            src_b[k] = 8'($urandom);
        end
        run_cmd("post_reset_trace", 8'hFF, 70, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mat_stream_ctrl.md
Name: mat_stream_ctrl

Overview:
- Front-end sequencer for the matrix-operation datapath (calc engine plus three 1024x8 BRAMs A, B, C, each 32x32 row-major).
- Accepts one command over a byte stream: opcode, then matrix A, then matrix B. Writes A and B into their BRAM write ports.
- Launches the calc engine with a one-cycle op_start and waits for finish.
- Streams the result back: 1024 bytes of matrix C, or a single trace byte.

Parameters:
- N_ELEM, 1024, elements per matrix. Address width is fixed at 10 bits.
- C_RD_LAT, 1, C BRAM read latency in cycles. Only 1 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_data  in  8  command/data byte in
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid&s_ready
- m_data  out  8  result byte out
- m_valid  out  1  result byte valid
- m_ready  in  1  downstream accepts when m_valid&m_ready
- addra_w  out  10  BRAM A write address
- dina  out  8  BRAM A write data
- wea  out  1  BRAM A write enable
- addrb_w  out  10  BRAM B write address
- dinb  out  8  BRAM B write data
- web  out  1  BRAM B write enable
- op  out  3  opcode to calc, held stable from START until DONE
- op_start  out  1  one-cycle launch pulse to calc
- finish  in  1  calc completion flag (sticky; cleared by calc on op_start)
- dout_C  in  8  calc result bus (trace value for ops 110/111)
- addrc_r  out  10  BRAM C read address
- doutc  in  8  BRAM C read data, valid one cycle after addrc_r
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (async on rst, all outputs and state):
  - s_ready=0, m_valid=0, m_data=0
  - wea=web=0; addra_w=addrb_w=addrc_r=0; dina=dinb=0
  - op=0, op_start=0, busy=0
  - state=IDLE, element counter cnt(11b)=0
- Reset mid-operation aborts immediately. Partially written BRAM contents are left as-is; no output byte is emitted.
- States: IDLE, LOAD_A, LOAD_B, START, WAIT, RD_ADDR, RD_DATA, OUT, TRACE_OUT.
- IDLE:
  - s_ready=1.
  - On handshake, latch op<=s_data[2:0] (bits 7:3 ignored), cnt<=0, go to LOAD_A.
- LOAD_A:
  - s_ready=1.
  - Each handshake: registered write wea=1, addra_w=cnt, dina=s_data on the next cycle; cnt++.
  - No handshake means no write and no gap penalty.
  - After the 1024th byte (cnt==1023 accepted): cnt<=0, go to LOAD_B.
- LOAD_B: identical to LOAD_A using web/addrb_w/dinb. After the 1024th byte, go to START.
- START:
  - s_ready=0.
  - op_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - Track flag seen_low, cleared at START and set when finish==0.
  - Leave WAIT only on finish==1 with seen_low==1. A stale finish left over from the previous run must never end WAIT.
  - No timeout.
  - On exit: if op is 110 or 111, capture m_data<=dout_C and go to TRACE_OUT. Otherwise cnt<=0 and go to RD_ADDR.
- RD_ADDR: drive addrc_r=cnt, go to RD_DATA.
- RD_DATA: m_data<=doutc, m_valid<=1, go to OUT.
- OUT:
  - Hold m_data/m_valid stable until m_ready.
  - On handshake: m_valid<=0. If cnt==1023, go to IDLE; else cnt++ and go to RD_ADDR.
  - Throughput is 3 cycles per byte when m_ready is held high.
- TRACE_OUT: m_valid=1 with the captured byte. On handshake, go to IDLE.
- The final byte's handshake in the input direction and the output direction can never coincide; s_ready=0 in all post-load states.
- BRAM writes in LOAD_A/LOAD_B are one-cycle registered pulses. A write may coincide with the next byte's handshake (back-to-back, 1 byte/cycle).

Test Plan:
- Add, A[k]=k[7:0], B[k]=1, all s_valid continuous: send opcode 0x00 then 2048 bytes. Expect exactly 2048 wea/web pulses, A written at addresses 0..1023. Model calc: op_start seen once. Expect 1024 output bytes, byte k=(k+1)[7:0].
- Transpose A (op 100): A[k]=k[7:0]. Expect output byte at address 32*i+j to equal A[32*j+i], i.e. byte 1=0x20 and byte 32=0x01.
- Trace (op 110), calc model drives dout_C=0x5A at finish: expect exactly one output byte 0x5A, then busy=0 and s_ready=1.
- Stale finish: finish held 1 from the previous run and dropped 2 cycles after op_start. Expect WAIT not exited until finish returns high after that drop.
- Backpressure: m_ready toggled 1-of-3 cycles and s_valid random 50%. Expect no lost or duplicated bytes, m_data stable while m_valid&!m_ready, and the output stream matching the add case.
- Reset asserted in LOAD_B at byte 500, then released. Expect all outputs at reset values asynchronously, state IDLE, and the next opcode byte accepted normally.
